barrel_rotr_pipe: RTL and testbench



---
 rtl/barrel_rotr_pipe_pkg.sv | 22 ++
 rtl/barrel_rotr_pipe_if.sv | 25 ++
 rtl/barrel_rotr_pipe_stage.sv | 72 +++++++
 rtl/barrel_rotr_pipe.sv | 51 +++++
 tb/tb_barrel_rotr_pipe.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_rotr_pipe_pkg.sv
// Shared constants and the constant-distance rotate helper for the
// pipelined rotate-right unit.
package barrel_rotr_pipe_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SHW_DEF   = 4;

  // Pure rotation: bit i of the result is bit (i + amount) mod WIDTH_DEF of data.
  function automatic logic [WIDTH_DEF-1:0] rotr_const(
    input logic [WIDTH_DEF-1:0] data,
    input int unsigned          amount
  );
    int unsigned a;
    a = amount % WIDTH_DEF;
    if (a == 32'd0) begin
      return data;
    end else begin
      return (data >> a) | (data << (32'(WIDTH_DEF) - a));
    end
  endfunction

endpackage

// File: rtl/barrel_rotr_pipe_if.sv
// Request/response handshake bundle of the rotate-right pipeline.
interface barrel_rotr_pipe_if #(
  parameter int WIDTH = barrel_rotr_pipe_pkg::WIDTH_DEF,
  parameter int SHW   = barrel_rotr_pipe_pkg::SHW_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   C;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] O;

  modport master (
    output in_valid, A, C, out_ready,
    input  in_ready, out_valid, O
  );

  modport slave (
    input  in_valid, A, C, out_ready,
    output in_ready, out_valid, O
  );

endinterface

// File: rtl/barrel_rotr_pipe_stage.sv
// One registered pipeline stage: optionally rotates right by the constant
// STEP and forwards the shift field to the stages below.
module rotr_stage
  import barrel_rotr_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_bit_i,
  input  logic [SHW-1:0]   rem_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   rem_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0] rot_s;

  generate
    if (WIDTH == WIDTH_DEF) begin : g_pkg_rot
      assign rot_s = rotr_const(data_i, STEP);
    end else begin : g_slice_rot
      assign rot_s = {data_i[STEP-1:0], data_i[WIDTH-1:STEP]};
    end
  endgenerate

  // An empty stage always accepts, so bubbles collapse toward the output.
  assign ready_o = !valid_q || ready_i;

  // Load from upstream when this stage can advance, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rem_d   = rem_q;
    if (ready_o) begin
      valid_d = valid_i;
      data_d  = shift_bit_i ? rot_s : data_i;
      rem_d   = rem_i;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
      rem_d   = rem_q;
    end
  end

  // Stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
      rem_q   <= {SHW{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign rem_o   = rem_q;

endmodule

// File: rtl/barrel_rotr_pipe.sv
// Pipelined logarithmic rotate-right: stage k rotates by 2^(SHW-1-k)
// under shift bit C[SHW-1-k]; SHW stages, elastic valid/ready chain.
module barrel_rotr_pipe
  import barrel_rotr_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  barrel_rotr_pipe_if.slave   bus
);

  // Index k is the input of stage k; index SHW is the pipeline output.
  logic             valid_s [SHW+1];
  logic             ready_s [SHW+1];
  logic [WIDTH-1:0] data_s  [SHW+1];
  logic [SHW-1:0]   sh_s    [SHW+1];

  assign valid_s[0]   = bus.in_valid;
  assign data_s[0]    = bus.A;
  assign sh_s[0]      = bus.C;
  assign ready_s[SHW] = bus.out_ready;

  assign bus.in_ready  = ready_s[0];
  assign bus.out_valid = valid_s[SHW];
  assign bus.O         = data_s[SHW];

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      rotr_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .STEP  (1 << (SHW - 1 - k))
      ) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_s[k]),
        .ready_o     (ready_s[k]),
        .data_i      (data_s[k]),
        .shift_bit_i (sh_s[k][SHW-1-k]),
        .rem_i       (sh_s[k]),
        .valid_o     (valid_s[k+1]),
        .ready_i     (ready_s[k+1]),
        .data_o      (data_s[k+1]),
        .rem_o       (sh_s[k+1])
      );
    end
  endgenerate

endmodule

// File: tb/tb_barrel_rotr_pipe.sv
// Self-checking bench for barrel_rotr_pipe: directed vectors, round trip,
// backpressure, randomized scoreboard and asynchronous reset mid-flight.
module tb_barrel_rotr_pipe;
  import barrel_rotr_pipe_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int S = SHW_DEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrel_rotr_pipe_if #(.WIDTH(W), .SHW(S)) bus ();

  barrel_rotr_pipe #(.WIDTH(W), .SHW(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] expq [$];

  // Reference rotations written bit by bit from the definition.
  function automatic logic [W-1:0] rotr_model(input logic [W-1:0] a, input int s);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = a[(i + s) % W];
    return r;
  endfunction

  function automatic logic [W-1:0] rotl_model(input logic [W-1:0] a, input int s);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[(i + s) % W] = a[i];
    return r;
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.A         = 16'h0000;
    bus.C         = 4'h0;
    bus.out_ready = 1'b1;
  endtask

  // One clock: sample handshakes at the falling edge, return just after the rising edge.
  task automatic step(output logic acc, output logic xfr, output logic ov, output logic [W-1:0] o);
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    xfr = bus.out_valid && bus.out_ready;
    ov  = bus.out_valid;
    o   = bus.O;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.O !== 16'h0000) begin n_fail++; $display("FAIL reset_O: got %h expected 0000", bus.O); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{16'hAAAA, 16'h8001, 16'h0001, 16'h1234};
    logic [S-1:0] tc [4] = '{4'd1, 4'd4, 4'd15, 4'd0};
    logic [W-1:0] te [4] = '{16'h5555, 16'h1800, 16'h0002, 16'h1234};
    logic acc, xfr, ov;
    logic [W-1:0] o, got;
    int lat;
    for (int t = 0; t < 4; t++) begin
      bus.in_valid  = 1'b1;
      bus.A         = ta[t];
      bus.C         = tc[t];
      bus.out_ready = 1'b1;
      step(acc, xfr, ov, o);
      bus.in_valid = 1'b0;
      lat = -1;
      got = 16'h0000;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        step(acc, xfr, ov, o);
        if (xfr) begin lat = cyc; got = o; break; end
      end
      n_tests++; if (lat != 4) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 4", t, lat); end
      n_tests++; if (got !== te[t]) begin n_fail++; $display("FAIL directed_O[%0d]: got %h expected %h", t, got, te[t]); end
    end
  endtask

  task automatic test_round_trip();
    logic acc, xfr, ov;
    logic [W-1:0] o;
    int nacc = 0, nx = 0, first = -1, last = -1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (nacc < 16) begin
        bus.in_valid = 1'b1;
        bus.A        = rotl_model(16'hC3A5, nacc);
        bus.C        = 4'(nacc);
      end else begin
        bus.in_valid = 1'b0;
      end
      step(acc, xfr, ov, o);
      if (acc) nacc++;
      if (xfr) begin
        n_tests++; if (o !== 16'hC3A5) begin n_fail++; $display("FAIL round_trip_O[%0d]: got %h expected c3a5", nx, o); end
        if (first < 0) first = cyc;
        last = cyc;
        nx++;
      end
    end
    n_tests++; if (nacc != 16) begin n_fail++; $display("FAIL round_trip_accepts: got %0d expected 16", nacc); end
    n_tests++; if (nx != 16) begin n_fail++; $display("FAIL round_trip_outputs: got %0d expected 16", nx); end
    n_tests++; if (first != 4) begin n_fail++; $display("FAIL round_trip_first: got %0d expected 4", first); end
    n_tests++; if (last - first != 15) begin n_fail++; $display("FAIL round_trip_consecutive: got span %0d expected 15", last - first); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] qa [6];
    logic [S-1:0] qc [6];
    logic acc, xfr, ov, acc5;
    logic [W-1:0] o, held, want;
    int idx = 0, got = 0;
    expq.delete();
    for (int i = 0; i < 6; i++) begin qa[i] = 16'($urandom); qc[i] = 4'($urandom_range(0, 15)); end
    bus.out_ready = 1'b0;
    acc5 = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      bus.in_valid = 1'b1;
      bus.A        = qa[idx];
      bus.C        = qc[idx];
      step(acc, xfr, ov, o);
      if (cyc == 4) acc5 = acc;
      if (acc) begin expq.push_back(rotr_model(qa[idx], int'(qc[idx]))); idx++; end
    end
    n_tests++; if (idx != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 4", idx); end
    n_tests++; if (acc5 !== 1'b0) begin n_fail++; $display("FAIL bp_accept_5th: got %b expected 0", acc5); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
    held = bus.O;
    want = expq[0];
    n_tests++; if (held !== want) begin n_fail++; $display("FAIL bp_head_O: got %h expected %h", held, want); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      step(acc, xfr, ov, o);
      n_tests++; if (ov !== 1'b1 || o !== held) begin n_fail++; $display("FAIL bp_hold: got valid %b O %h expected valid 1 O %h", ov, o, held); end
    end
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && (got < 6 || idx < 6); cyc++) begin
      if (idx < 6) begin
        bus.in_valid = 1'b1;
        bus.A        = qa[idx];
        bus.C        = qc[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      step(acc, xfr, ov, o);
      if (acc) begin expq.push_back(rotr_model(qa[idx], int'(qc[idx]))); idx++; end
      if (xfr) begin
        want = (expq.size() > 0) ? expq.pop_front() : ~o;
        n_tests++; if (o !== want) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", got, o, want); end
        got++;
      end
    end
    bus.in_valid = 1'b0;
    n_tests++; if (got != 6) begin n_fail++; $display("FAIL bp_results: got %0d expected 6", got); end
  endtask

  task automatic test_random();
    logic acc, xfr, ov, ordy, pending, prev_stall;
    logic [W-1:0] o, pa, want, prev_o;
    logic [S-1:0] pc;
    int sent = 0, recv = 0, cyc = 0;
    expq.delete();
    pending = 1'b0; prev_stall = 1'b0; prev_o = 16'h0000; pa = 16'h0000; pc = 4'h0;
    while ((sent < 200 || expq.size() > 0) && cyc < 6000) begin
      if (!pending && sent < 200 && $urandom_range(0, 3) != 0) begin
        pa = 16'($urandom);
        pc = 4'($urandom_range(0, 15));
        pending = 1'b1;
      end
      bus.in_valid  = pending;
      bus.A         = pa;
      bus.C         = pc;
      ordy          = 1'($urandom_range(0, 1));
      bus.out_ready = ordy;
      step(acc, xfr, ov, o);
      if (prev_stall) begin
        n_tests++; if (ov !== 1'b1 || o !== prev_o) begin n_fail++; $display("FAIL rand_stall_hold: got valid %b O %h expected valid 1 O %h", ov, o, prev_o); end
      end
      if (acc) begin expq.push_back(rotr_model(pa, int'(pc))); sent++; pending = 1'b0; end
      if (xfr) begin
        want = (expq.size() > 0) ? expq.pop_front() : ~o;
        n_tests++; if (o !== want) begin n_fail++; $display("FAIL rand_O[%0d]: got %h expected %h", recv, o, want); end
        recv++;
      end
      prev_stall = ov && !ordy;
      prev_o     = o;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_tests++; if (sent != 200 || recv != 200) begin n_fail++; $display("FAIL rand_count: got sent %0d recv %0d expected 200 200", sent, recv); end
  endtask

  task automatic test_reset_midflight();
    logic acc, xfr, ov;
    logic [W-1:0] o, got;
    int spurious = 0, lat = -1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = 16'($urandom) | 16'h0101;
      bus.C        = 4'($urandom_range(0, 15));
      step(acc, xfr, ov, o);
    end
    bus.in_valid = 1'b0;
    step(acc, xfr, ov, o);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", bus.out_valid); end
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = 16'hFFFF;
    bus.C        = 4'd3;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.O !== 16'h0000) begin n_fail++; $display("FAIL rst_async_O: got %h expected 0000", bus.O); end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %b expected 1", bus.in_ready); end
    for (int i = 0; i < 10; i++) begin
      step(acc, xfr, ov, o);
      if (ov) spurious++;
    end
    n_tests++; if (spurious != 0) begin n_fail++; $display("FAIL rst_stale: got %0d stale outputs expected 0", spurious); end
    bus.in_valid = 1'b1;
    bus.A        = 16'h00F0;
    bus.C        = 4'd4;
    step(acc, xfr, ov, o);
    bus.in_valid = 1'b0;
    got = 16'h0000;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step(acc, xfr, ov, o);
      if (xfr) begin lat = cyc; got = o; break; end
    end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL rst_new_latency: got %0d expected 4", lat); end
    n_tests++; if (got !== 16'h000F) begin n_fail++; $display("FAIL rst_new_O: got %h expected 000f", got); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_directed();
    test_round_trip();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
